// File: rtl/fp16add_sched.sv
// Two-requester round-robin front end for a fixed-latency fp16 pipelined adder.
// Optional grant counters are enabled with macro FP16ADD_SCHED_PERFCNT_EN.
module fp16add_sched #(
  parameter int LAT = 3
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_res,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp0_res,
  output logic [15:0] rsp1_res,
  output logic        busy
`ifdef FP16ADD_SCHED_PERFCNT_EN
  ,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
`endif
);

  logic          pri_q;
  logic [15:0]   add_a_q, add_b_q;
  // Stage 0 is loaded at the accept edge; stage LAT lines up with add_res.
  logic [LAT:0]  vld_pipe_q, id_pipe_q;
  logic          rsp0_valid_q, rsp1_valid_q;
  logic [15:0]   rsp0_res_q, rsp1_res_q;
  logic          gnt0, gnt1, gnt;

  always_comb begin
    gnt0 = RSTN & req0_valid & (~req1_valid | ~pri_q);
    gnt1 = RSTN & req1_valid & (~req0_valid |  pri_q);
    gnt  = gnt0 | gnt1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pri_q        <= 1'b0;
      add_a_q      <= 16'h0;
      add_b_q      <= 16'h0;
      vld_pipe_q   <= '0;
      id_pipe_q    <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_res_q   <= 16'h0;
      rsp1_res_q   <= 16'h0;
    end else begin
      if (gnt) begin
        pri_q   <= gnt0;
        add_a_q <= gnt1 ? req1_a : req0_a;
        add_b_q <= gnt1 ? req1_b : req0_b;
      end
      vld_pipe_q   <= {vld_pipe_q[LAT-1:0], gnt};
      id_pipe_q    <= {id_pipe_q[LAT-1:0], gnt1};
      rsp0_valid_q <= vld_pipe_q[LAT] & ~id_pipe_q[LAT];
      rsp1_valid_q <= vld_pipe_q[LAT] &  id_pipe_q[LAT];
      if (vld_pipe_q[LAT] && !id_pipe_q[LAT]) rsp0_res_q <= add_res;
      if (vld_pipe_q[LAT] &&  id_pipe_q[LAT]) rsp1_res_q <= add_res;
    end
  end

`ifdef FP16ADD_SCHED_PERFCNT_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt0_q <= 16'h0;
      cnt1_q <= 16'h0;
    end else begin
      if (gnt0 && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (gnt1 && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_res   = rsp0_res_q;
  assign rsp1_res   = rsp1_res_q;
  assign busy       = |vld_pipe_q;

endmodule

// File: tb/tb_fp16add_sched.sv
// Directed bench for fp16add_sched with a LAT-stage behavioural fp16 adder.
module tb_fp16add_sched;
  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [15:0] add_a, add_b, add_res;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_res, rsp1_res;
  logic        busy;
`ifdef FP16ADD_SCHED_PERFCNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int total = 0;
  int bad = 0;

  fp16add_sched #(.LAT(LAT)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_res(add_res),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_res(rsp0_res), .rsp1_res(rsp1_res),
    .busy(busy)
`ifdef FP16ADD_SCHED_PERFCNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 CLK = ~CLK;

  // Positive-normal fp16 add, truncating; enough for the directed operands.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  ea, eb, d;
    logic [11:0] ma, mb, s;
    ea = a[14:10]; eb = b[14:10];
    ma = {1'b0, 1'b1, a[9:0]}; mb = {1'b0, 1'b1, b[9:0]};
    if (ea < eb) begin
      ea = b[14:10]; eb = a[14:10];
      ma = {1'b0, 1'b1, b[9:0]}; mb = {1'b0, 1'b1, a[9:0]};
    end
    d = ea - eb;
    mb = (d > 5'd11) ? 12'h0 : (mb >> d);
    s = ma + mb;
    if (s[11]) return {1'b0, ea + 5'd1, s[10:1]};
    return {1'b0, ea, s[9:0]};
  endfunction

  logic [15:0] apipe [LAT] = '{default: 16'h0};
  always_ff @(posedge CLK) begin
    apipe[0] <= fadd(add_a, add_b);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_res = apipe[LAT-1];

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset;
    RSTN = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1; tick; tick;
    RSTN = 1'b1;
  endtask

  task automatic test_reset;
    RSTN = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready); end
    total++; if (add_a !== 16'h0 || add_b !== 16'h0) begin bad++;
      $display("FAIL reset_add got=%h/%h want=0000/0000", add_a, add_b); end
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++;
      $display("FAIL reset_rspv got=%b%b want=00", rsp0_valid, rsp1_valid); end
    total++; if (rsp0_res !== 16'h0 || rsp1_res !== 16'h0) begin bad++;
      $display("FAIL reset_rspres got=%h/%h want=0000/0000", rsp0_res, rsp1_res); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_single;
    do_reset;
    req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL single_ready got=%b%b want=10", req0_ready, req1_ready); end
    tick;
    req0_valid = 1'b0;
    total++; if (add_a !== 16'h3C00) begin bad++;
      $display("FAIL single_add_a got=%h want=3c00", add_a); end
    total++; if (busy !== 1'b1) begin bad++;
      $display("FAIL single_busy got=%b want=1", busy); end
    for (int k = 1; k <= 5; k++) begin
      tick;
      total++; if (rsp0_valid !== (k == 4) || rsp1_valid !== 1'b0) begin bad++;
        $display("FAIL single_rspv k=%0d got=%b%b want=%b0", k, rsp0_valid, rsp1_valid, (k == 4)); end
      if (k >= 4) begin
        total++; if (rsp0_res !== 16'h4000) begin bad++;
          $display("FAIL single_res k=%0d got=%h want=4000", k, rsp0_res); end
      end
    end
  endtask

  task automatic test_contention;
    int g;
    do_reset;
    req0_a = 16'h3C00; req0_b = 16'h3C00;
    req1_a = 16'h4000; req1_b = 16'h4000;
    for (int n = 0; n < 12; n++) begin
      req0_valid = (n < 6); req1_valid = (n < 6);
      #1;
      total++; if (req0_ready !== (n < 6 && n % 2 == 0) || req1_ready !== (n < 6 && n % 2 == 1)) begin bad++;
        $display("FAIL cont_ready n=%0d got=%b%b want=%b%b", n, req0_ready, req1_ready,
                 (n < 6 && n % 2 == 0), (n < 6 && n % 2 == 1)); end
      tick;
      g = n - 4;
      total++; if (rsp0_valid !== (g >= 0 && g < 6 && g % 2 == 0) ||
                   rsp1_valid !== (g >= 0 && g < 6 && g % 2 == 1)) begin bad++;
        $display("FAIL cont_rspv n=%0d got=%b%b", n, rsp0_valid, rsp1_valid); end
      if (g >= 0 && g < 6) begin
        total++; if ((g % 2 == 0 && rsp0_res !== 16'h4000) || (g % 2 == 1 && rsp1_res !== 16'h4400)) begin bad++;
          $display("FAIL cont_res n=%0d got=%h/%h want=%s", n, rsp0_res, rsp1_res,
                   (g % 2 == 0) ? "4000" : "4400"); end
      end
      total++; if (busy !== (n <= 5 + LAT)) begin bad++;
        $display("FAIL cont_busy n=%0d got=%b want=%b", n, busy, (n <= 5 + LAT)); end
    end
  endtask

  task automatic test_pointer;
    do_reset;
    req1_valid = 1'b1; req1_a = 16'h3C00; req1_b = 16'h3C00;
    #1;
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++;
      $display("FAIL ptr_first got=%b%b want=01", req0_ready, req1_ready); end
    tick;
    req0_valid = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL ptr_second got=%b%b want=10", req0_ready, req1_ready); end
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) tick;
  endtask

  task automatic test_reset_midflight;
    do_reset;
    req0_valid = 1'b1; req0_a = 16'h4000; req0_b = 16'h4000;
    repeat (3) tick;
    req0_valid = 1'b0;
    RSTN = 1'b0;
    #1;
    total++; if (add_a !== 16'h0 || busy !== 1'b0) begin bad++;
      $display("FAIL mid_async got add_a=%h busy=%b want=0000/0", add_a, busy); end
    tick;
    RSTN = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin bad++;
        $display("FAIL mid_after k=%0d got rspv=%b%b busy=%b want=00/0", k, rsp0_valid, rsp1_valid, busy); end
    end
  endtask

  task automatic test_bubble;
    do_reset;
    req0_a = 16'h4000; req0_b = 16'h4000;
    for (int n = 0; n < 11; n++) begin
      req0_valid = (n == 0 || n == 2 || n == 3);
      #1;
      tick;
      total++; if (rsp0_valid !== (n == 4 || n == 6 || n == 7) || rsp1_valid !== 1'b0) begin bad++;
        $display("FAIL bubble_rspv n=%0d got=%b%b want=%b0", n, rsp0_valid, rsp1_valid,
                 (n == 4 || n == 6 || n == 7)); end
      if (rsp0_valid) begin
        total++; if (rsp0_res !== 16'h4400) begin bad++;
          $display("FAIL bubble_res n=%0d got=%h want=4400", n, rsp0_res); end
      end
    end
    req0_valid = 1'b0;
  endtask

`ifdef FP16ADD_SCHED_PERFCNT_EN
  task automatic test_perfcnt;
    do_reset;
    total++; if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin bad++;
      $display("FAIL perf_reset got=%h/%h want=0000/0000", cnt0, cnt1); end
    req0_valid = 1'b1;
    repeat (70000) tick;
    req0_valid = 1'b0;
    total++; if (cnt0 !== 16'hFFFF || cnt1 !== 16'h0) begin bad++;
      $display("FAIL perf_sat got=%h/%h want=ffff/0000", cnt0, cnt1); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_pointer;
    test_reset_midflight;
    test_bubble;
`ifdef FP16ADD_SCHED_PERFCNT_EN
    test_perfcnt;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp16add_sched.md
FP16ADD_SCHED -- requirements
Module: fp16add_sched

Interface
REQ-001 SHALL have parameter LAT, default 3, meaning the fixed latency in clock edges of the attached fp16pipeadd, legal range 1..8.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n presents an operand pair.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 bit each: the scheduler accepts requester n this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 16 bits each: fp16 operands of requester n.
REQ-007 SHALL have ports add_a and add_b, output, 16 bits each: registered operands driven to the adder.
REQ-008 SHALL have port add_res, input, 16 bits: adder result.
REQ-009 SHALL have ports rsp0_valid and rsp1_valid, output, 1 bit each: a result for requester n is present; there is no backpressure.
REQ-010 SHALL have ports rsp0_res and rsp1_res, output, 16 bits each: the result for requester n.
REQ-011 SHALL have port busy, output, 1 bit: at least one operation is in flight.

Function
REQ-012 SHALL compute reqN_ready combinationally from reqN_valid and the 1-bit round-robin pointer pri; at most one ready is high per cycle.
- REQ-013 SHALL follow these arbitration rules:
  - Both valid: grant requester pri.
  - One valid: grant that requester.
  - None valid: no grant.
REQ-014 SHALL, on every grant to requester g, set pri to ~g at the same edge; with no grant, pri holds.
REQ-015 SHALL register the granted requester's a and b onto add_a and add_b at the accept edge E0; with no grant, add_a and add_b hold their values.
REQ-016 SHALL track each issue in a LAT-deep shift register of {valid, id}; bubbles shift as valid=0.
REQ-017 SHALL sample add_res at edge E0+LAT+1 and drive it onto rspId_res with rspId_valid=1 for exactly one cycle, so that response latency is LAT+1 edges after acceptance.
REQ-018 SHALL deassert the other requester's rsp valid in that cycle; rspN_res holds its last value while rspN_valid=0.
REQ-019 SHALL sustain full throughput: one issue per cycle, with back-to-back issues producing back-to-back responses in issue order.
REQ-020 SHALL drive busy high iff any shift-register stage, or the response register about to be set, holds valid=1.
REQ-021 SHALL leave a requester holding valid without ready to retry each cycle; starvation SHALL NOT exceed 1 cycle when both requesters are continuously valid.

Reset
REQ-022 SHALL, on RSTN low, asynchronously clear the following, independent of CLK:
  - pri to 0.
  - add_a and add_b to 16'h0.
  - All shift-register valids and ids to 0.
  - rsp0_valid and rsp1_valid to 0.
  - rsp0_res and rsp1_res to 16'h0.
REQ-023 SHALL drop in-flight operations if reset asserts mid-operation; no response SHALL ever be emitted for them after release.
REQ-024 SHALL hold both readies low while RSTN is low.
REQ-025 SHALL allow the first grant at the first rising edge with RSTN high.

Configuration
REQ-026 SHALL, with macro FP16ADD_SCHED_PERFCNT_EN defined, add outputs cnt0 and cnt1, 16 bits each, counting grants per requester.
- These counters SHALL saturate at 16'hFFFF.
- These counters SHALL reset to 0 on RSTN low.
REQ-027 SHALL, without FP16ADD_SCHED_PERFCNT_EN, omit cnt0, cnt1 and their logic entirely, with all other behaviour identical.

Verification
REQ-028 SHALL cover a single request with LAT=3: req0 holds 3C00/3C00 (1.0+1.0) for one cycle -> req0_ready=1, add_a=3C00 after edge E0, rsp0_valid=1 with rsp0_res=4000 at edge E0+4, and rsp1_valid stays 0.
REQ-029 SHALL cover contention: both valid continuously for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; responses alternate in the same order; busy stays 1 until the last response.
REQ-030 SHALL cover a pointer update: req1 alone for one cycle, then both valid -> req0 is granted next, since pri=0 after the req1 grant.
REQ-031 SHALL cover reset mid-flight: 3 issues, then RSTN pulsed low for 1 cycle -> no rsp valid afterwards, busy=0, add_a=0000.
REQ-032 SHALL cover a bubble pattern: req0 valid on cycles 0, 2 and 3 -> rsp0_valid on cycles 4, 6 and 7 only.
REQ-033 SHALL cover PERFCNT: with FP16ADD_SCHED_PERFCNT_EN defined and 70000 consecutive req0-only grants -> cnt0=FFFF and cnt1=0000.
